stream_sample_fifo: RTL and testbench
=====================================

// Module: stream_sample_fifo
// PURPOSE
//  Elastic buffer plus sample-rate pacer for streaming mode. Decouples bursty SPI writes of
//  stream samples from the fixed audio rate: each SPI stream-sample write pushes one byte, and a
//  programmable timer pops one byte per sample period. sample_out replaces the raw stream
//  register as the stream-mode audio source ahead of volume scaling and the delta-sigma DAC.
// PARAMETERS
//  DEPTH   8    FIFO entries; power of two, 2..32
//  AW      3    log2(DEPTH); derived, do not override
//  DIV_W   16   width of rate divider
// PORTS
//  clk         in   1      system clock (50 MHz)
//  rst         in   1      reset; asynchronous, active-high
//  wr_valid    in   1      1-cycle pulse: SPI wrote the stream-sample register
//  wr_data     in   8      sample byte, unsigned, valid with wr_valid
//  enable      in   1      stream_mode & ena; gates the pacer
//  rate_div    in   DIV_W  clocks per sample minus one (1040 -> ~48.03 kHz)
//  flush       in   1      synchronous FIFO clear
//  clr_flags   in   1      clears sticky overrun/underrun
//  sample_out  out  8      current audio sample
//  sample_tick out  1      1-cycle pulse at each sample boundary
//  level       out  AW+1   entries held, 0..DEPTH
//  full        out  1      level == DEPTH
//  empty       out  1      level == 0
//  overrun     out  1      sticky: write dropped while full
//  underrun    out  1      sticky: tick found FIFO empty
// BEHAVIOUR
//  Reset: sample_out=8'h00, sample_tick=0, level=0, empty=1, full=0, flags=0, pointers=0,
//   pacer count=0. Asserting rst mid-operation discards buffered samples immediately.
//  Pacer: down-counter. enable=0 -> count held at rate_div, no ticks. enable=1 -> when count==0
//   assert sample_tick for that cycle and reload rate_div, else decrement. rate_div=0 -> tick
//   every cycle. rate_div changes take effect at next reload. First tick after enable rises
//   occurs rate_div+1 cycles later.
//  Pop: on the sample_tick cycle, if !empty, read head, advance rd pointer; sample_out shows the
//   byte from the next cycle (1-cycle latency tick->sample_out). If empty: sample_out holds its
//   last value, underrun<=1.
//  Push: wr_valid & !full -> store at wr pointer, advance. wr_valid & full -> byte dropped,
//   overrun<=1, contents unchanged.
//  Simultaneous push+pop: full -> pop frees slot, push accepted, level unchanged. Empty -> pop
//   underruns (no bypass), push accepted, level becomes 1. Otherwise both proceed, level unchanged.
//  Latency: push at edge N -> level/empty update visible after N; earliest pop of it is a tick
//   in cycle N+1.
//  flush: priority over push and pop in the same cycle; pointers and level to 0, pacer reloaded
//   to rate_div; sample_out and sticky flags unchanged.
//  clr_flags: clears both flags; a new overrun/underrun event in the same cycle wins (flag = 1).
//  Pointers are AW bits and wrap modulo DEPTH; level is tracked separately (AW+1 bits), full and
//   empty are decoded from level, all outputs registered or decoded from registers only.
// STRUCTURE
//  Shared synth package: SAMPLE_W=8, SAMPLE_SILENCE=8'h00, RATE_DIV_48K=16'd1040.
//  Sub-module sample_rate_timer (DIV_W down-counter, enable, reload, tick) instantiated once;
//   storage is a DEPTH x 8 flop array written in place, no SRAM macro.
// TESTING
//  1 Reset: rst pulse mid-stream -> sample_out=00, level=0, empty=1, flags=0, no tick in reset.
//  2 Pacing: rate_div=4, enable=1, push 10,20,30 -> ticks every 5 clk; sample_out 10,20,30 each
//    one cycle after its tick; then 4th tick holds 30 and sets underrun.
//  3 Overrun: enable=0, push 9 bytes 01..09 -> full after 8, 09 dropped, overrun=1, level=8;
//    then enable, drain -> outputs 01..08 in order.
//  4 Full push+pop: FIFO full, wr_valid coincident with tick -> level stays 8, new byte read
//    out last, overrun stays 0.
//  5 Flush vs push: flush and wr_valid same cycle -> level=0, byte lost, sample_out unchanged;
//    clr_flags coincident with underrun event -> underrun=1.
//  6 Wrap: rate_div=0, 20 back-to-back pushes interleaved with pops -> pointers wrap, output
//    order matches input, no spurious flags.

Source files
------------

// File: rtl/stream_sample_fifo_pkg.sv
// Shared definitions for the stream-mode sample path.
//   SAMPLE_W       : width of one audio sample byte
//   SAMPLE_SILENCE : value shown on sample_out after reset
//   RATE_DIV_48K   : rate_div value giving ~48.03 kHz from a 50 MHz clock
package stream_sample_fifo_pkg;

    localparam int unsigned SAMPLE_W = 8;
    localparam logic [SAMPLE_W-1:0] SAMPLE_SILENCE = 8'h00;
    localparam logic [15:0] RATE_DIV_48K = 16'd1040;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Sticky error flags reported to the register file.
    typedef struct packed {
        logic overrun;
        logic underrun;
    } fifo_flags_t;

endpackage

// File: rtl/sample_rate_timer.sv
// Sample-rate pacer: a down-counter that emits a registered one-cycle tick every
// rate_div+1 clocks while enabled.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   enable    : run the counter; while low the count is held at rate_div
//   reload    : force the count back to rate_div (used by FIFO flush)
//   rate_div  : clocks per sample minus one, sampled at each reload
//   tick      : one-cycle pulse at each sample boundary
module sample_rate_timer #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             reload,
    input  logic [DIV_W-1:0] rate_div,
    output logic             tick
);

    logic [DIV_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;

    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (reload || !enable) begin
            count_d = rate_div;
        end else if (count_q == '0) begin
            tick_d  = 1'b1;
            count_d = rate_div;
        end else begin
            count_d = count_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    // Registered tick lands rate_div+1 cycles after enable rises.
    assign tick = tick_q;

endmodule

// File: rtl/stream_sample_fifo.sv
// Elastic sample buffer with sample-rate pacer for stream mode. SPI writes push bytes,
// the pacer pops one byte per sample period onto sample_out.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   wr_valid    : one-cycle push strobe, wr_data carries the byte
//   enable      : gates the pacer
//   rate_div    : clocks per sample minus one
//   flush       : synchronous clear of pointers/level, reloads the pacer
//   clr_flags   : clears sticky overrun/underrun
//   sample_out  : current audio sample (updates the cycle after a tick)
//   sample_tick : one-cycle pulse at each sample boundary
//   level       : entries held, full/empty decoded from it
//   overrun     : sticky, a write was dropped while full
//   underrun    : sticky, a tick found the buffer empty
module stream_sample_fifo
    import stream_sample_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DIV_W = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                enable,
    input  logic [DIV_W-1:0]    rate_div,
    input  logic                flush,
    input  logic                clr_flags,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_tick,
    output logic [AW:0]         level,
    output logic                full,
    output logic                empty,
    output logic                overrun,
    output logic                underrun
);

    localparam logic [AW:0] LevelFull = DEPTH[AW:0];

    sample_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    sample_t       sample_q, sample_d;
    fifo_flags_t   flags_q, flags_d;

    logic push, pop, ovr_evt, udr_evt;

    sample_rate_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .reload   (flush),
        .rate_div (rate_div),
        .tick     (sample_tick)
    );

    assign full  = (level_q == LevelFull);
    assign empty = (level_q == '0);

    always_comb begin
        // Flush wins over both sides; a pop frees the slot a full-cycle push needs.
        pop     = sample_tick && !empty && !flush;
        push    = wr_valid && (!full || pop) && !flush;
        ovr_evt = wr_valid && !flush && !push;
        // No bypass: a tick on an empty buffer underruns even if a push lands now.
        udr_evt = sample_tick && empty && !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        sample_d = sample_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                sample_d = mem_q[rd_ptr_q];
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end

        // A fresh event in the clearing cycle keeps the flag set.
        flags_d.overrun  = (flags_q.overrun  && !clr_flags) || ovr_evt;
        flags_d.underrun = (flags_q.underrun && !clr_flags) || udr_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sample_q <= SAMPLE_SILENCE;
            flags_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sample_q <= sample_d;
            flags_q  <= flags_d;
        end
    end

    // Storage needs no reset: level gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign sample_out = sample_q;
    assign level      = level_q;
    assign overrun    = flags_q.overrun;
    assign underrun   = flags_q.underrun;

endmodule

// File: tb/tb_stream_sample_fifo.sv
module tb_stream_sample_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        enable;
    logic [15:0] rate_div;
    logic        flush;
    logic        clr_flags;
    logic [7:0]  sample_out;
    logic        sample_tick;
    logic [3:0]  level;
    logic        full;
    logic        empty;
    logic        overrun;
    logic        underrun;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stream_sample_fifo #(
        .DEPTH(8),
        .DIV_W(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .enable      (enable),
        .rate_div    (rate_div),
        .flush       (flush),
        .clr_flags   (clr_flags),
        .sample_out  (sample_out),
        .sample_tick (sample_tick),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .overrun     (overrun),
        .underrun    (underrun)
    );

    // Advance one clock; outputs are then read 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    // Step until sample_tick is seen; the current cycle is then the tick cycle.
    task automatic wait_tick(output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            n++;
            if (sample_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int  n;
        bit  ok;
        rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; enable = 1'b0;
        rate_div = 16'd0; flush = 1'b0; clr_flags = 1'b0;
        step(); step();
        total++; if (sample_out !== 8'h00) begin bad++; $display("FAIL rst_sample got=%h want=00", sample_out); end
        total++; if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL rst_level got=%0d/%b/%b want=0/1/0", level, empty, full); end
        total++; if (overrun !== 1'b0 || underrun !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b want=00", overrun, underrun); end
        rst = 1'b0;
        step();
        push_byte(8'h3c);
        push_byte(8'h4d);
        enable = 1'b1;
        step(); step();
        total++; if (sample_out !== 8'h3c || level !== 4'd1) begin bad++; $display("FAIL pre_rst got=%h/%0d want=3c/1", sample_out, level); end
        rst = 1'b1;
        #1;
        total++; if (sample_out !== 8'h00 || level !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL mid_rst got=%h/%0d/%b want=00/0/1", sample_out, level, empty); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (sample_tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b want=0", sample_tick); end
        end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL rst_udr got=%b want=0", underrun); end
        enable = 1'b0;
        rst = 1'b0;
        step(); step();
        n = 0; ok = 1'b1;
    endtask

    task automatic test_pacing();
        int n;
        bit ok;
        logic [7:0] exp_q [3] = '{8'h10, 8'h20, 8'h30};
        rate_div = 16'd4;
        push_byte(8'h10);
        push_byte(8'h20);
        push_byte(8'h30);
        total++; if (level !== 4'd3) begin bad++; $display("FAIL pace_level got=%0d want=3", level); end
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_tick(n, ok);
            total++; if (!ok || n != ((k == 0) ? 5 : 4)) begin bad++; $display("FAIL pace_period got=%0d want=%0d", n, (k == 0) ? 5 : 4); end
            total++; if (sample_out !== ((k == 0) ? 8'h00 : exp_q[k-1])) begin bad++; $display("FAIL pace_pre got=%h", sample_out); end
            step();
            total++; if (sample_out !== exp_q[k]) begin bad++; $display("FAIL pace_out got=%h want=%h", sample_out, exp_q[k]); end
        end
        wait_tick(n, ok);
        total++; if (!ok || n != 4 || underrun !== 1'b0) begin bad++; $display("FAIL pace_tick4 got=%0d/%b want=4/0", n, underrun); end
        step();
        enable = 1'b0;
        total++; if (sample_out !== 8'h30 || underrun !== 1'b1) begin bad++; $display("FAIL pace_udr got=%h/%b want=30/1", sample_out, underrun); end
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL pace_clr got=%b want=0", underrun); end
    endtask

    task automatic test_overrun();
        int n;
        bit ok;
        for (int i = 1; i <= 9; i++) begin
            push_byte(8'(i));
            if (i == 8) begin
                total++; if (full !== 1'b1 || level !== 4'd8 || overrun !== 1'b0) begin bad++; $display("FAIL ovr_full got=%b/%0d/%b want=1/8/0", full, level, overrun); end
            end
        end
        total++; if (overrun !== 1'b1 || level !== 4'd8) begin bad++; $display("FAIL ovr_flag got=%b/%0d want=1/8", overrun, level); end
        enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            wait_tick(n, ok);
            step();
            total++; if (!ok || sample_out !== 8'(i)) begin bad++; $display("FAIL ovr_drain got=%h want=%h", sample_out, 8'(i)); end
        end
        enable = 1'b0;
        total++; if (empty !== 1'b1 || underrun !== 1'b0) begin bad++; $display("FAIL ovr_end got=%b/%b want=1/0", empty, underrun); end
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr got=%b want=0", overrun); end
    endtask

    task automatic test_full_push_pop();
        int n;
        bit ok;
        logic [7:0] exp_q [8] = '{8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7, 8'haa};
        for (int i = 0; i < 8; i++) push_byte(8'ha0 + 8'(i));
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fpp_full got=%b want=1", full); end
        enable = 1'b1;
        wait_tick(n, ok);
        wr_valid = 1'b1;
        wr_data  = 8'haa;
        step();
        wr_valid = 1'b0;
        total++; if (!ok || level !== 4'd8 || full !== 1'b1) begin bad++; $display("FAIL fpp_level got=%0d want=8", level); end
        total++; if (overrun !== 1'b0 || sample_out !== 8'ha0) begin bad++; $display("FAIL fpp_pop got=%b/%h want=0/a0", overrun, sample_out); end
        for (int i = 0; i < 8; i++) begin
            wait_tick(n, ok);
            step();
            total++; if (!ok || sample_out !== exp_q[i]) begin bad++; $display("FAIL fpp_drain got=%h want=%h", sample_out, exp_q[i]); end
        end
        enable = 1'b0;
        total++; if (empty !== 1'b1 || overrun !== 1'b0 || underrun !== 1'b0) begin bad++; $display("FAIL fpp_end got=%b/%b/%b want=1/0/0", empty, overrun, underrun); end
    endtask

    task automatic test_flush();
        int n;
        bit ok;
        push_byte(8'h55);
        push_byte(8'h66);
        total++; if (level !== 4'd2) begin bad++; $display("FAIL fl_pre got=%0d want=2", level); end
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        total++; if (level !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL fl_level got=%0d/%b want=0/1", level, empty); end
        total++; if (sample_out !== 8'haa || overrun !== 1'b0) begin bad++; $display("FAIL fl_keep got=%h/%b want=aa/0", sample_out, overrun); end
        enable = 1'b1;
        wait_tick(n, ok);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        enable    = 1'b0;
        total++; if (!ok || underrun !== 1'b1 || sample_out !== 8'haa) begin bad++; $display("FAIL fl_clr_race got=%b/%h want=1/aa", underrun, sample_out); end
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL fl_clr got=%b want=0", underrun); end
    endtask

    task automatic test_wrap();
        int n;
        bit ok;
        logic [7:0] seq [22];
        seq[0] = 8'hb0;
        seq[1] = 8'hb1;
        for (int i = 0; i < 20; i++) seq[i+2] = 8'hc0 + 8'(i);
        rate_div = 16'd0;
        push_byte(8'hb0);
        push_byte(8'hb1);
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1'b1;
            wr_data  = seq[i+2];
            step();
            if (i >= 1) begin
                total++; if (sample_out !== seq[i-1]) begin bad++; $display("FAIL wrap_out i=%0d got=%h want=%h", i, sample_out, seq[i-1]); end
            end
        end
        wr_valid = 1'b0;
        enable   = 1'b0;
        step();
        total++; if (sample_out !== seq[19] || level !== 4'd2) begin bad++; $display("FAIL wrap_tail got=%h/%0d want=%h/2", sample_out, level, seq[19]); end
        total++; if (overrun !== 1'b0 || underrun !== 1'b0) begin bad++; $display("FAIL wrap_flags got=%b%b want=00", overrun, underrun); end
        rate_div = 16'd4;
        step();
        enable = 1'b1;
        for (int i = 20; i < 22; i++) begin
            wait_tick(n, ok);
            step();
            total++; if (!ok || sample_out !== seq[i]) begin bad++; $display("FAIL wrap_drain got=%h want=%h", sample_out, seq[i]); end
        end
        enable = 1'b0;
        total++; if (empty !== 1'b1 || underrun !== 1'b0) begin bad++; $display("FAIL wrap_end got=%b/%b want=1/0", empty, underrun); end
    endtask

    initial begin
        test_reset();
        test_pacing();
        test_overrun();
        test_full_push_pop();
        test_flush();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
